data_sync_tx: RTL



---
 rtl/data_sync_tx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/data_sync_tx.sv
// Source-domain launcher for a multi-bit CDC bus: holds a word on unsync_bus and
// frames it with a registered bus_enable level (setup, hold, gap) so each word yields one destination pulse.
module data_sync_tx #(
    parameter int BUS_WIDTH   = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 tx_done,
    output logic                 busy
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]   bus_q, bus_d;
    logic                   en_q, en_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;

    // Next-state, counter and next-output computation; outputs are the flop values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        en_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Capture only at the accept edge; later tx_data changes never reach the bus.
                if (tx_valid) begin
                    bus_d   = tx_data;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_LOAD;
                en_d    = 1'b1;
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                    en_d    = 1'b0;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    en_d    = 1'b1;
                end
            end
            ST_GAP: begin
                // Data stays on the bus through the gap so the destination never sees it move near an edge.
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops bus_enable immediately, abandoning any word in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            bus_q   <= {BUS_WIDTH{1'b0}};
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign unsync_bus = bus_q;
    assign bus_enable = en_q;
    assign tx_done    = done_q;
    assign tx_ready   = ready_q;
    assign busy       = busy_q;

endmodule
